// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative CORDIC vectoring engine: (x, y) -> gain-scaled magnitude and phase

module cordic_vectoring #(
    parameter int NUM_STAGES = 13,
    parameter int WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH:0]          mag_out,
    output logic signed [WIDTH-1:0] angle_out
);

    localparam int  CNT_W = $clog2(NUM_STAGES + 1);
    localparam int  DW    = WIDTH + 2;
    localparam real PI    = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    // Taylor series is only used for arguments <= 0.5, where it converges fast.
    function automatic real atan_series(input real v);
        real term;
        real sum;
        sum  = 0.0;
        term = v;
        for (int k = 0; k < 60; k++) begin
            sum  = sum + term / real'(2 * k + 1);
            term = -term * v * v;
        end
        return sum;
    endfunction

    function automatic logic [NUM_STAGES-1:0][WIDTH-1:0] build_atan();
        logic [NUM_STAGES-1:0][WIDTH-1:0] t;
        real    a;
        longint r;
        for (int i = 0; i < NUM_STAGES; i++) begin
            a    = (i == 0) ? PI / 4.0 : atan_series(1.0 / (2.0 ** i));
            r    = longint'(a / PI * (2.0 ** (WIDTH - 1)));
            t[i] = WIDTH'(r);
        end
        return t;
    endfunction

    localparam logic [NUM_STAGES-1:0][WIDTH-1:0] ATAN = build_atan();

    state_t                 state;
    state_t                 state_next;
    logic signed [DW-1:0]   x;
    logic signed [DW-1:0]   y;
    logic [WIDTH-1:0]       z;
    logic [CNT_W-1:0]       cnt;
    logic                   zero_flag;

    logic signed [DW-1:0]   x_ext;
    logic signed [DW-1:0]   y_ext;
    logic signed [DW-1:0]   x_shift;
    logic signed [DW-1:0]   y_shift;
    logic [WIDTH-1:0]       atan_cur;
    logic                   last_iter;

    always_comb begin
        x_ext     = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext     = {{2{y_in[WIDTH-1]}}, y_in};
        x_shift   = x >>> cnt;
        y_shift   = y >>> cnt;
        atan_cur  = ATAN[cnt];
        last_iter = (cnt == CNT_W'(NUM_STAGES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mag_out    = '0;
        angle_out  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ITER;
            end
            ITER: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (!zero_flag) begin
                    mag_out   = x[WIDTH:0];
                    angle_out = z;
                end
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Left half-plane inputs are folded by pi so iterations only cover +-pi/2.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (x_in[WIDTH-1]) begin
                            x <= -x_ext;
                            y <= -y_ext;
                            z <= {1'b1, {(WIDTH-1){1'b0}}};
                        end else begin
                            x <= x_ext;
                            y <= y_ext;
                            z <= '0;
                        end
                        zero_flag <= (x_in == '0) && (y_in == '0);
                        cnt       <= '0;
                    end
                end
                ITER: begin
                    if (!y[DW-1]) begin
                        x <= x + y_shift;
                        y <= y - x_shift;
                        z <= z + atan_cur;
                    end else begin
                        x <= x - y_shift;
                        y <= y + x_shift;
                        z <= z - atan_cur;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring against an atan2/sqrt model

module tb_cordic_vectoring;

    localparam int  W    = 32;
    localparam int  NS   = 13;
    localparam real PI   = 3.14159265358979323846;
    localparam int  MINV = 32'sh8000_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                out_valid;
    logic                out_ready;
    logic [W:0]          mag_out;
    logic signed [W-1:0] angle_out;

    int  total = 0;
    int  bad   = 0;
    real kgain;

    always #5 clk = ~clk;

    cordic_vectoring #(.NUM_STAGES(NS), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    function automatic logic [31:0] exp_angle(input real xv, input real yv);
        real    a;
        longint l;
        a = $atan2(yv, xv) / PI * (2.0 ** 31);
        l = longint'(a);
        return l[31:0];
    endfunction

    function automatic real exp_mag(input real xv, input real yv);
        return kgain * $sqrt(xv * xv + yv * yv);
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_mag(input string tag, input longint got, input real exp);
        real d;
        bit  ok;
        total++;
        d  = real'(got) - exp;
        if (d < 0.0) d = -d;
        ok = (d <= exp / 2048.0 + 2.0);
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0.1f", tag, got, exp);
        end
    endtask

    task automatic chk_ang(input string tag, input logic [31:0] got, input logic [31:0] exp);
        logic [31:0] d;
        int          sd;
        bit          ok;
        total++;
        d  = got - exp;
        sd = signed'(d);
        ok = (sd <= (1 << 18)) && (sd >= -(1 << 18));
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input int xv, input int yv);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        x_in     = xv;
        y_in     = yv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, NS);
    endtask

    task automatic check_res(input string tag, input int xv, input int yv);
        chk_ang({tag, "_angle"}, angle_out, exp_angle(real'(xv), real'(yv)));
        chk_mag({tag, "_mag"}, longint'(mag_out), exp_mag(real'(xv), real'(yv)));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, longint'(in_ready), 1);
    endtask

    task automatic op(input string tag, input int xv, input int yv);
        send(xv, yv);
        wait_done(tag);
        check_res(tag, xv, yv);
        release_out(tag);
    endtask

    initial begin
        int          seen;
        int          xv;
        int          yv;
        longint      lx;
        longint      ly;
        logic [31:0] a;
        real         th;

        kgain = 1.0;
        for (int i = 0; i < NS; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_mag", longint'(mag_out), 0);
        chk("rst_angle", longint'(angle_out), 0);
        rst = 1'b0;
        @(negedge clk);

        op("pos_x", 1 << 30, 0);
        op("pos_y", 0, 1 << 30);
        op("neg_x", -(1 << 30), 0);
        op("neg_diag", -(1 << 30), -(1 << 30));

        send(0, 0);
        wait_done("zero");
        chk("zero_mag", longint'(mag_out), 0);
        chk("zero_angle", longint'(angle_out), 0);
        release_out("zero");

        op("extreme", MINV, MINV);

        send(1 << 29, 3 << 28);
        wait_done("bp");
        x_in      = -(1 << 29);
        y_in      = 1 << 28;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_valid", longint'(out_valid), 1);
            check_res("bp_hold", 1 << 29, 3 << 28);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_idle", longint'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("bp_next");
        check_res("bp_next", -(1 << 29), 1 << 28);
        release_out("bp_next");

        send(1 << 30, 1 << 29);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", longint'(in_ready), 1);
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_mag", longint'(mag_out), 0);
        chk("abort_angle", longint'(angle_out), 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        op("after_abort", -(3 << 28), 5 << 27);

        for (int n = 0; n < 200; n++) begin
            do begin
                xv = $urandom;
                yv = $urandom;
                lx = xv;
                ly = yv;
            end while (lx * lx + ly * ly < (64'sd1 << 48));
            op("rand", xv, yv);
        end

        for (int n = 0; n < 1000; n++) begin
            a  = $urandom;
            th = real'(signed'(a)) * PI / (2.0 ** 31);
            xv = int'(1.0e9 * $cos(th));
            yv = int'(1.0e9 * $sin(th));
            send(xv, yv);
            wait_done("rt");
            chk_ang("roundtrip_angle", angle_out, a);
            release_out("rt");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC vectoring-mode engine: the inverse of the rotation-mode `cordic` core in the same comparison suite. Accepts a Cartesian vector (x, y) and returns its gain-scaled magnitude and phase angle. It uses the same multi-stage iterative architecture and the same `NUM_STAGES`/`WIDTH` parameterisation. The rotation core is verified by round-trip: its sin/cos outputs are fed into this block and must return the original angle.

## Interface
- `NUM_STAGES`, 13: micro-rotations per operation, 1..WIDTH-2.
- `WIDTH`, 32: input and angle width, ≥ 8.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; one clock, reset synchronous and active-high.
- `in_valid` in 1: x_in/y_in valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `x_in` in WIDTH: signed two's-complement x.
- `y_in` in WIDTH: signed two's-complement y.
- `out_valid` out 1: result valid; high only in DONE.
- `out_ready` in 1: downstream accepts result.
- `mag_out` out WIDTH+1: unsigned, K·sqrt(x²+y²), where K = ∏sqrt(1+2^-2i) (≈1.646760 for 13 stages); no gain compensation.
- `angle_out` out WIDTH: signed binary angle; 2^(WIDTH-1) LSB = π, range [-π, π).

## Operation
- Datapath: x, y are signed WIDTH+2, sign-extended from inputs. z is WIDTH bits and wraps modulo 2^WIDTH. Iteration counter is ceil(log2(NUM_STAGES+1)) bits.
- Constant table atan_i = round(atan(2^-i)/π · 2^(WIDTH-1)), for i = 0..NUM_STAGES-1. For WIDTH=32: atan_0 = 0x2000_0000, atan_1 = 0x12E4_051E.
- States: IDLE, ITER, DONE.
- IDLE: in_ready=1. On in_valid, the block captures the input with quadrant fold:
  - x_in<0: x=-x_in, y=-y_in, z=0x8000_0000 (scaled to WIDTH).
  - else: x=x_in, y=y_in, z=0.
  - zero_flag = (x_in==0 && y_in==0).
  - cnt=0, goto ITER.
- ITER, iteration i=cnt, using arithmetic shifts of the pre-update values:
  - y≥0: x+=y>>>i, y-=x>>>i, z+=atan_i.
  - y<0: x-=y>>>i, y+=x>>>i, z-=atan_i.
  - cnt++. After the iteration with cnt==NUM_STAGES-1, goto DONE.
- DONE: out_valid=1. mag_out=x[WIDTH:0], which is non-negative by construction. angle_out=z. If zero_flag, both outputs are forced to 0. On out_ready, goto IDLE.
- No overlap: in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- x_in = -2^(WIDTH-1) is legal. Negation is performed at WIDTH+2 bits, so there is no overflow.
- Reset: state IDLE, in_ready=1, out_valid=0, mag_out=0, angle_out=0, x/y/z/cnt=0, zero_flag=0.
- Reset while in ITER or DONE aborts the operation. The result is lost, and no out_valid pulse occurs.

## Timing
- Accept edge = rising edge with IDLE && in_valid.
- out_valid rises NUM_STAGES edges after the accept edge (13 for defaults).
- out_valid holds while out_ready=0. mag_out/angle_out are stable for the whole time out_valid=1.
- Result handshake edge (DONE && out_ready) → IDLE. in_ready is high the following cycle.
- Minimum period between accepts: NUM_STAGES+1 cycles, when out_ready is held high.
- in_ready and out_valid decode from the state register only. There is no combinational path from any input.
- Accuracy at defaults: |angle error| ≤ 2^18 LSB (≈3.8e-4 rad, compared modulo 2^WIDTH). |mag error| ≤ 2^-11 relative to K·|v|.

## Test plan
- Reset then x=2^30, y=0: out_valid in cycle 13 after accept; angle ≈ 0x0000_0000; mag ≈ 1 768 195 389 (within tolerance).
- x=0, y=2^30 → angle ≈ 0x4000_0000. x=-2^30, y=0 → angle ≈ 0x8000_0000 (±π, checked modulo 2^32). x=y=-2^30 → angle ≈ 0xA000_0000; mag ≈ 1.64676·2^30·√2.
- x=y=0 → mag_out=0, angle_out=0 exactly. Extreme input x=y=-2^31 → no overflow; angle ≈ 0xA000_0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → outputs stable and in_ready=0. Release → IDLE next cycle; the new vector is accepted.
- Assert rst at iteration 6 → next cycle IDLE, out_valid=0, all outputs 0. A following operation completes correctly.
- Round-trip: drive the rotation-mode `cordic` with 1000 random angles and feed its cos/sin outputs here → recovered angle within 2^18 LSB of the original.
